// File: rtl/hv_encoder_seq.sv
// Microcoded sequencer for the HV encoder: walks a writable program memory,
// issuing one control word per cycle with a single hardware loop and IM stalls.
module hv_encoder_seq #(
  parameter int CtrlWidth = 36,
  parameter int NumInstr  = 32,
  parameter int IterWidth = 16,
  localparam int InstWidth = CtrlWidth + 2,
  localparam int AddrWidth = $clog2(NumInstr)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  output logic                 busy_o,
  output logic                 done_o,
  input  logic [AddrWidth-1:0] loop_start_i,
  input  logic [AddrWidth-1:0] loop_end_i,
  input  logic [IterWidth-1:0] num_iter_i,
  input  logic                 prog_wr_en_i,
  input  logic [AddrWidth-1:0] prog_addr_i,
  input  logic [InstWidth-1:0] prog_data_i,
  output logic                 im_req_o,
  input  logic                 im_valid_i,
  output logic                 ctrl_valid_o,
  output logic [CtrlWidth-1:0] ctrl_o,
  output logic [AddrWidth-1:0] pc_o,
  output logic [IterWidth-1:0] iter_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NumInstr - 1);

  logic [InstWidth-1:0] mem [NumInstr];

  state_t               state_reg;
  logic [AddrWidth-1:0] pc_reg;
  logic [IterWidth-1:0] iter_reg;
  logic [AddrWidth-1:0] loop_start_reg;
  logic [AddrWidth-1:0] loop_end_reg;
  logic [IterWidth-1:0] num_iter_reg;

  logic [InstWidth-1:0] inst;
  logic                 imw;
  logic                 halt;
  logic                 running;
  logic                 fire;
  logic                 loop_en;
  logic                 at_loop_end;
  logic [IterWidth:0]   iter_inc;
  logic [IterWidth:0]   eff_iter;

  // Writes are accepted only while idle so a running program is never disturbed.
  always_ff @(posedge clk_i) begin
    if (prog_wr_en_i && state_reg == IDLE) begin
      mem[prog_addr_i] <= prog_data_i;
    end
  end

  always_comb begin
    inst        = mem[pc_reg];
    imw         = inst[CtrlWidth];
    halt        = inst[CtrlWidth+1];
    running     = (state_reg == RUN);
    fire        = running && !abort_i && (!imw || im_valid_i);
    loop_en     = (loop_start_reg <= loop_end_reg);
    at_loop_end = loop_en && (pc_reg == loop_end_reg);
    iter_inc    = {1'b0, iter_reg} + (IterWidth+1)'(1);
    // A zero iteration count still runs the body once.
    eff_iter    = (num_iter_reg == '0) ? (IterWidth+1)'(1) : {1'b0, num_iter_reg};
  end

  assign im_req_o     = running && imw;
  assign ctrl_valid_o = fire;
  assign ctrl_o       = fire ? inst[CtrlWidth-1:0] : '0;
  assign busy_o       = running;
  assign done_o       = (state_reg == DONE) && !abort_i;
  assign pc_o         = pc_reg;
  assign iter_o       = iter_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= IDLE;
      pc_reg         <= '0;
      iter_reg       <= '0;
      loop_start_reg <= '0;
      loop_end_reg   <= '0;
      num_iter_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_i) begin
            loop_start_reg <= loop_start_i;
            loop_end_reg   <= loop_end_i;
            num_iter_reg   <= num_iter_i;
            pc_reg         <= '0;
            iter_reg       <= '0;
            state_reg      <= RUN;
          end
        end
        RUN: begin
          if (abort_i) begin
            state_reg <= IDLE;
          end else if (fire) begin
            if (halt) begin
              state_reg <= DONE;
            end else if (at_loop_end) begin
              iter_reg <= iter_inc[IterWidth-1:0];
              if (iter_inc < eff_iter) begin
                pc_reg <= loop_start_reg;
              end else if (pc_reg == LastAddr) begin
                // Loop exit on the final slot has nowhere to fall through to.
                state_reg <= DONE;
              end else begin
                pc_reg <= pc_reg + AddrWidth'(1);
              end
            end else if (pc_reg == LastAddr) begin
              state_reg <= DONE;
            end else begin
              pc_reg <= pc_reg + AddrWidth'(1);
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hv_encoder_seq.sv
// Directed and randomized checks of hv_encoder_seq against a trace-level
// reference model of the program walk.
module tb_hv_encoder_seq;

  localparam int CW = 36;
  localparam int NI = 32;
  localparam int IW = 16;
  localparam int INW = CW + 2;
  localparam int AW = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic           busy, done;
  logic [AW-1:0]  loop_start = '0;
  logic [AW-1:0]  loop_end = '0;
  logic [IW-1:0]  num_iter = '0;
  logic           prog_wr_en = 1'b0;
  logic [AW-1:0]  prog_addr = '0;
  logic [INW-1:0] prog_data = '0;
  logic           im_req;
  logic           im_valid = 1'b0;
  logic           ctrl_valid;
  logic [CW-1:0]  ctrl;
  logic [AW-1:0]  pc;
  logic [IW-1:0]  iter;

  int n_checks = 0;
  int n_fail = 0;

  logic [INW-1:0] mem_m [NI];
  int cfg_ls, cfg_le, cfg_n;

  always #5 clk = ~clk;

  hv_encoder_seq #(.CtrlWidth(CW), .NumInstr(NI), .IterWidth(IW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
    .busy_o(busy), .done_o(done),
    .loop_start_i(loop_start), .loop_end_i(loop_end), .num_iter_i(num_iter),
    .prog_wr_en_i(prog_wr_en), .prog_addr_i(prog_addr), .prog_data_i(prog_data),
    .im_req_o(im_req), .im_valid_i(im_valid),
    .ctrl_valid_o(ctrl_valid), .ctrl_o(ctrl), .pc_o(pc), .iter_o(iter)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] rnd_ctrl();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[CW-1:0];
  endfunction

  task automatic load(input int addr, input logic halt, input logic imw, input logic [CW-1:0] c);
    mem_m[addr] = {halt, imw, c};
    prog_wr_en = 1'b1;
    prog_addr  = AW'(addr);
    prog_data  = {halt, imw, c};
    tick();
    prog_wr_en = 1'b0;
  endtask

  // Expected issue order: straight-line walk from 0, the loop body repeated
  // max(n,1) times, stopping at HALT or after the last slot.
  task automatic build_trace(output int q[$], output int it);
    int p, eff;
    bit en;
    q.delete();
    eff = (cfg_n == 0) ? 1 : cfg_n;
    en  = (cfg_ls <= cfg_le);
    p = 0;
    it = 0;
    while (q.size() < 4000) begin
      q.push_back(p);
      if (mem_m[p][CW+1]) break;
      if (en && p == cfg_le) begin
        it++;
        if (it < eff) begin
          p = cfg_ls;
          continue;
        end
      end
      if (p == NI - 1) break;
      p++;
    end
  endtask

  // stall >= 0: IMW instructions see im_valid low for exactly 'stall' cycles.
  // stall < 0: im_valid is random every cycle.
  task automatic run(input int stall, output int issues, output int cycles, output int reqs);
    int q[$];
    int exp_it, idx, waited;
    logic [INW-1:0] ins;
    logic v, f;
    build_trace(q, exp_it);
    loop_start = AW'(cfg_ls);
    loop_end   = AW'(cfg_le);
    num_iter   = IW'(cfg_n);
    start = 1'b1;
    tick();
    start = 1'b0;
    loop_start = AW'($urandom);
    loop_end   = AW'($urandom);
    num_iter   = IW'($urandom);
    idx = 0; waited = 0; issues = 0; cycles = 0; reqs = 0;
    while (idx < q.size() && cycles < 3000) begin
      ins = mem_m[q[idx]];
      if (stall >= 0) v = ins[CW] ? (waited >= stall) : 1'($urandom);
      else            v = 1'($urandom);
      im_valid = v;
      f = !ins[CW] || v;
      #4;
      chk("run_busy", busy, 1);
      chk("run_done", done, 0);
      chk("run_pc", pc, q[idx]);
      chk("run_im_req", im_req, ins[CW]);
      chk("run_ctrl_valid", ctrl_valid, f);
      chk("run_ctrl", ctrl, f ? ins[CW-1:0] : '0);
      $display("cycle %0d pc=%0d valid=%0b ctrl=%0h", cycles, pc, ctrl_valid, ctrl);
      if (im_req) reqs++;
      if (f) begin idx++; issues++; waited = 0; end
      else waited++;
      cycles++;
      @(posedge clk);
      #1;
    end
    chk("run_budget", cycles < 3000, 1);
    im_valid = 1'b0;
    #4;
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    chk("done_ctrl_valid", ctrl_valid, 0);
    chk("done_pc", pc, q[q.size()-1]);
    chk("done_iter", iter, exp_it);
    tick();
    #4;
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    tick();
  endtask

  initial begin
    int iss, cyc, rq, hpos;
    logic [CW-1:0] a, b, c;

    // Reset state
    tick(); tick();
    #4;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ctrl_valid", ctrl_valid, 0);
    chk("rst_ctrl", ctrl, 0);
    chk("rst_im_req", im_req, 0);
    chk("rst_pc", pc, 0);
    chk("rst_iter", iter, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Three-instruction program, loop disabled
    a = rnd_ctrl(); b = rnd_ctrl(); c = rnd_ctrl();
    load(0, 0, 0, a); load(1, 0, 0, b); load(2, 1, 0, c);
    cfg_ls = 1; cfg_le = 0; cfg_n = 0;
    run(0, iss, cyc, rq);
    chk("abc_issues", iss, 3);
    chk("abc_busy_cycles", cyc, 3);

    // Loop 1..2 four times
    for (int i = 0; i < 4; i++) load(i, (i == 3), 0, rnd_ctrl());
    cfg_ls = 1; cfg_le = 2; cfg_n = 4;
    run(0, iss, cyc, rq);
    chk("loop4_issues", iss, 10);
    cfg_n = 0;
    run(0, iss, cyc, rq);
    chk("loop0_issues", iss, 4);

    // IMW stall of five cycles on instruction 1
    load(1, 0, 1, rnd_ctrl());
    cfg_ls = 1; cfg_le = 0; cfg_n = 0;
    run(5, iss, cyc, rq);
    chk("imw_req_cycles", rq, 6);
    chk("imw_stall_cycles", cyc - iss, 5);

    // Abort during the stall at pc=1 (valid high in the abort cycle); start+abort together
    abort = 1'b1; start = 1'b1;
    loop_start = 1; loop_end = 0; num_iter = 0;
    tick();
    start = 1'b0; abort = 1'b0; im_valid = 1'b0;
    #4;
    chk("start_wins_busy", busy, 1);
    chk("abort_first_issue", ctrl_valid, 1);
    tick();
    #4;
    chk("abort_stall_req", im_req, 1);
    chk("abort_stall_valid", ctrl_valid, 0);
    tick();
    abort = 1'b1; im_valid = 1'b1;
    #4;
    chk("abort_cycle_valid", ctrl_valid, 0);
    chk("abort_cycle_ctrl", ctrl, 0);
    chk("abort_cycle_done", done, 0);
    tick();
    abort = 1'b0; im_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #4;
      chk("abort_idle_busy", busy, 0);
      chk("abort_idle_done", done, 0);
      tick();
    end

    // Program write during RUN is ignored; rerun shows original contents
    start = 1'b1;
    tick();
    start = 1'b0;
    prog_wr_en = 1'b1; prog_addr = 2; prog_data = {2'b00, rnd_ctrl()};
    tick();
    prog_wr_en = 1'b1; prog_addr = 3; prog_data = {2'b00, rnd_ctrl()};
    abort = 1'b1;
    tick();
    prog_wr_en = 1'b0; abort = 1'b0;
    tick();
    run(0, iss, cyc, rq);
    chk("wr_in_run_issues", iss, 4);

    // Randomized programs; first two have no HALT
    for (int r = 0; r < 8; r++) begin
      hpos = 10 + int'($urandom_range(0, 21));
      for (int i = 0; i < NI; i++)
        load(i, (r >= 2) && (i == hpos), ($urandom_range(0, 3) == 0), rnd_ctrl());
      if (r == 0) begin
        cfg_ls = 1; cfg_le = 0; cfg_n = 0;
      end else begin
        cfg_ls = int'($urandom_range(0, 30));
        cfg_le = int'($urandom_range(0, 30));
        cfg_n  = int'($urandom_range(0, 3));
      end
      run(-1, iss, cyc, rq);
      if (r == 0) chk("nohalt_issues", iss, 32);
    end

    // Reset mid-run
    load(5, 0, 0, rnd_ctrl());
    cfg_ls = 1; cfg_le = 0;
    start = 1'b1;
    tick();
    start = 1'b0; im_valid = 1'b1;
    tick(); tick();
    rst = 1'b1;
    tick();
    #4;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_ctrl_valid", ctrl_valid, 0);
    chk("midrst_ctrl", ctrl, 0);
    chk("midrst_im_req", im_req, 0);
    chk("midrst_pc", pc, 0);
    chk("midrst_iter", iter, 0);
    tick();
    rst = 1'b0; im_valid = 1'b0;
    tick();
    #4;
    chk("midrst_no_done", done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hv_encoder_seq.md
Name: hv_encoder_seq

Overview:
- Microcoded sequencer that drives the HV encoder control ports (ALU/bundler/register-file/query-HV selects and enables) one control word per cycle.
- Holds a small writable program memory and walks it with a program counter.
- Supports one hardware loop, item-memory stall handshake, and a start/busy/done handshake to the host CSR block.
- Sits between the CSR/host interface and the encoder datapath; a thin wrapper slices ctrl_o into encoder fields.

Parameters:
- CtrlWidth, 36, width of the encoder control word.
- NumInstr, 32, program memory depth.
- IterWidth, 16, width of the loop iteration count.
- InstWidth, CtrlWidth+2, derived; bit CtrlWidth = IMW (wait for item memory), bit CtrlWidth+1 = HALT.
- AddrWidth, $clog2(NumInstr), derived.

Ports:
- clk_i  in  1  clock; one clock; reset is synchronous and active-high.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  start program; honoured only in IDLE.
- abort_i  in  1  abort the running program; go to IDLE next cycle.
- busy_o  out  1  high in RUN.
- done_o  out  1  one-cycle pulse after HALT issues.
- loop_start_i  in  AddrWidth  loop body first address; sampled at start.
- loop_end_i  in  AddrWidth  loop body last address; sampled at start.
- num_iter_i  in  IterWidth  loop iterations, sampled at start; 0 behaves as 1.
- prog_wr_en_i  in  1  program memory write enable; IDLE only, ignored otherwise.
- prog_addr_i  in  AddrWidth  program write address.
- prog_data_i  in  InstWidth  program write data.
- im_req_o  out  1  current instruction needs item-memory data.
- im_valid_i  in  1  item-memory data valid this cycle.
- ctrl_valid_o  out  1  ctrl_o is being issued this cycle.
- ctrl_o  out  CtrlWidth  encoder control word; all-zero when not issuing.
- pc_o  out  AddrWidth  current program counter.
- iter_o  out  IterWidth  completed loop iterations.

Behaviour:
- Reset: state IDLE; pc, iter, and latched loop configuration are 0; all outputs 0. Program memory contents are not reset.
- Program memory is a register array with combinational read at pc. A write lands next cycle.
- FSM states are IDLE, RUN, DONE.
- IDLE:
  - If start_i is high, latch the loop configuration, set pc=0 and iter=0, and go to RUN.
  - The first issue can occur in the cycle after start_i.
- RUN:
  - inst = mem[pc]; fire = !IMW | im_valid_i.
  - im_req_o = IMW, combinational.
  - When fire is high: ctrl_valid_o=1 and ctrl_o=inst[CtrlWidth-1:0]. Otherwise ctrl_valid_o=0, ctrl_o=0 and pc holds (stall, no issue).
  - Next pc on fire, in priority order:
    1. HALT: go to DONE; pc holds.
    2. pc==loop_end and iter+1 < max(num_iter,1): pc=loop_start, iter+1.
    3. pc==loop_end otherwise: iter+1, pc+1.
    4. pc==NumInstr-1: treated as HALT.
    5. Otherwise pc+1.
  - Loop exit leaves iter equal to the effective count.
  - loop_start > loop_end: the loop is disabled and the program runs straight through.
- DONE: done_o=1 for exactly one cycle, then IDLE. pc and iter hold until the next start.
- abort_i in RUN or DONE: next state is IDLE with no issue in the abort cycle; ctrl_o=0, and done_o is not pulsed. abort_i has priority over fire and HALT.
- start_i outside IDLE is ignored. start_i and abort_i together in IDLE: start wins.
- rst_i mid-program: next cycle is in the IDLE reset state; no done_o.
- Encoder side effects (bund_valid, reg_wr_en, qhv_wen) occur only on issue cycles, because ctrl_o is zeroed when not issuing.

Test Plan:
- Load 3 instructions (A, B, C with HALT), start → ctrl_o = A, B, C on consecutive cycles after start; done_o pulses the cycle after C; busy_o high for 3 cycles.
- Loop: loop_start=1, loop_end=2, num_iter=4, program 0..3 with HALT at 3 → issue order 0,1,2,1,2,1,2,1,2,3; iter_o=4 at done.
- num_iter=0 with the same program → body runs once, order 0,1,2,3.
- IMW on instruction 1, im_valid_i low for 5 cycles → im_req_o high for 6 cycles, ctrl_valid_o low for 5 cycles, ctrl_o=0 during the stall, single issue when valid rises.
- abort_i during the stall at pc=1 → next cycle IDLE, busy_o=0, done_o never pulses. A prog_wr_en_i during RUN leaves memory unchanged (readback via rerun).
- No HALT in a 32-entry program → 32 issues, implicit halt at pc=31, done_o pulses once. rst_i asserted mid-run → all outputs 0 next cycle.
